// File: rtl/processor_pkg.sv
// Shared processor definitions: fetch state encoding, NOP and branch opcodes,
// and field widths used by the fetch stage and the hazard unit.
package processor_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALLED  = 2'd1,
    ST_FLUSHING = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NOP_ENC       = 16'h0000;
  localparam logic [3:0]  BRANCH_OPCODE = 4'b1011;
  localparam int          OPCODE_W      = 4;
  localparam int          BUBBLE_W      = 2;

endpackage

// File: rtl/fetch_bubble_counter.sv
// Post-flush bubble countdown: loaded on a flush, decremented per bubble edge,
// paused otherwise. done means the current decrement reaches zero.
module fetch_bubble_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/fetch_stage_register.sv
// PC register plus IF/ID pipeline register with stall hold, flush redirect and
// NOP bubbles. Define FETCH_PERF_COUNTERS_EN to add saturating stall/flush counters.
module fetch_stage_register
  import processor_pkg::*;
#(
  parameter int                 DATA_W       = 16,
  parameter logic [DATA_W-1:0]  PC_RESET     = '0,
  parameter int                 PC_STEP      = 2,
  parameter int                 FLUSH_CYCLES = 1,
  parameter logic [DATA_W-1:0]  NOP_INST     = DATA_W'(NOP_ENC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic [3:0]        if_opcode,
  output logic              if_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;
  logic              bub_load, bub_dec, bub_done;

  fetch_bubble_counter #(.CNT_W(BUBBLE_W)) u_bubble (
    .clock    (clock),
    .reset    (reset),
    .load     (bub_load),
    .load_val (BUBBLE_W'(FLUSH_CYCLES - 1)),
    .dec      (bub_dec),
    .done     (bub_done)
  );

  // Priority: flush > stall > advance.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    bub_load   = 1'b0;
    bub_dec    = 1'b0;
    if (flush) begin
      pc_d       = branch_target;
      if_pc_d    = '0;
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
      bub_load   = 1'b1;
      state_d    = (FLUSH_CYCLES > 1) ? ST_FLUSHING : ST_RUN;
    end else if (!stall_n) begin
      state_d = ST_STALLED;
    end else if (state_q == ST_FLUSHING) begin
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
      bub_dec    = 1'b1;
      if (bub_done) state_d = ST_RUN;
    end else begin
      if_inst_d  = imem_data;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + DATA_W'(PC_STEP);
      state_d    = ST_RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= PC_RESET;
      if_pc_q    <= '0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign if_opcode = if_inst_q[DATA_W-1 -: OPCODE_W];

`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!flush && !stall_n && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush && (flush_cnt_q != 16'hFFFF))              flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage_register.sv
// Self-checking bench for fetch_stage_register (FLUSH_CYCLES=2): directed scenarios
// plus randomized traffic against a behavioural model of the fetch rules.
module tb_fetch_stage_register;

  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_n = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] imem_addr, imem_data, if_pc, if_inst;
  logic [3:0]  if_opcode;
  logic        if_valid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] stall_count, flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: architectural values plus bubbles still owed.
  logic [15:0] m_pc, m_if_pc, m_if_inst;
  logic        m_if_valid;
  int          m_bub;
  int          m_stalls, m_flushes;

  always #5 clock = ~clock;

  fetch_stage_register #(
    .DATA_W(16), .PC_RESET(16'h0000), .PC_STEP(2), .FLUSH_CYCLES(FC), .NOP_INST(16'h0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall_n       (stall_n),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_opcode     (if_opcode),
    .if_valid      (if_valid)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .stall_count   (stall_count),
    .flush_count   (flush_count)
`endif
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] h;
    case (a)
      16'h0000: h = 16'h1111;
      16'h0002: h = 16'h2222;
      16'h0004: h = 16'h3333;
      default:  h = (a * 16'h9E37) ^ 16'hC3A5;
    endcase
    return h;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic model_reset();
    m_pc = 16'h0000; m_if_pc = 16'h0000; m_if_inst = 16'h0000; m_if_valid = 1'b0;
    m_bub = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step(input logic f, input logic s, input logic [15:0] bt);
    if (f) begin
      m_pc = bt; m_if_pc = 16'h0000; m_if_inst = 16'h0000; m_if_valid = 1'b0;
      m_bub = FC - 1;
      if (m_flushes < 65535) m_flushes++;
    end else if (!s) begin
      m_bub = 0;
      if (m_stalls < 65535) m_stalls++;
    end else if (m_bub > 0) begin
      m_if_inst = 16'h0000; m_if_valid = 1'b0;
      m_bub--;
    end else begin
      m_if_inst = mem_word(m_pc); m_if_pc = m_pc; m_if_valid = 1'b1;
      m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic tick(input logic f, input logic s, input logic [15:0] bt);
    flush = f; stall_n = s; branch_target = bt;
    @(posedge clock);
    model_step(f, s, bt);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (imem_addr !== 16'h0000 || if_pc !== 16'h0000 || if_inst !== 16'h0000 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%h pc=%h inst=%h valid=%b, required 0000 0000 0000 0",
               imem_addr, if_pc, if_inst, if_valid);
    end
  endtask

  task automatic test_advance();
    logic [15:0] exp_inst [3];
    exp_inst[0] = 16'h1111; exp_inst[1] = 16'h2222; exp_inst[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 16'h0000);
      n_checks++;
      if (if_inst !== exp_inst[i] || if_pc !== 16'(2 * i) || if_valid !== 1'b1 ||
          imem_addr !== 16'(2 * i + 2)) begin
        n_fail++;
        $display("FAIL advance_%0d: inst=%h pc=%h valid=%b addr=%h, required %h %h 1 %h",
                 i, if_inst, if_pc, if_valid, imem_addr, exp_inst[i], 16'(2 * i), 16'(2 * i + 2));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 16'h0000);
      n_checks++;
      if (imem_addr !== 16'h0006 || if_inst !== 16'h3333 || if_pc !== 16'h0004 || if_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: addr=%h inst=%h pc=%h valid=%b, required 0006 3333 0004 1",
                 i, imem_addr, if_inst, if_pc, if_valid);
      end
    end
    tick(1'b0, 1'b1, 16'h0000);
    n_checks++;
    if (if_inst !== mem_word(16'h0006) || if_pc !== 16'h0006 || if_valid !== 1'b1 || imem_addr !== 16'h0008) begin
      n_fail++;
      $display("FAIL stall_release: inst=%h pc=%h valid=%b addr=%h, required %h 0006 1 0008",
               if_inst, if_pc, if_valid, imem_addr, mem_word(16'h0006));
    end
  endtask

  // Flush with redirect, one further bubble, then the target instruction.
  task automatic flush_sequence(input string name, input logic s_on_flush, input logic [15:0] bt);
    tick(1'b1, s_on_flush, bt);
    n_checks++;
    if (if_valid !== 1'b0 || if_inst !== 16'h0000 || if_pc !== 16'h0000 || imem_addr !== bt) begin
      n_fail++;
      $display("FAIL %s_edge: valid=%b inst=%h pc=%h addr=%h, required 0 0000 0000 %h",
               name, if_valid, if_inst, if_pc, imem_addr, bt);
    end
    tick(1'b0, 1'b1, 16'h0000);
    n_checks++;
    if (if_valid !== 1'b0 || if_inst !== 16'h0000 || imem_addr !== bt) begin
      n_fail++;
      $display("FAIL %s_bubble: valid=%b inst=%h addr=%h, required 0 0000 %h",
               name, if_valid, if_inst, imem_addr, bt);
    end
    tick(1'b0, 1'b1, 16'h0000);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== bt || if_inst !== mem_word(bt) || imem_addr !== bt + 16'd2) begin
      n_fail++;
      $display("FAIL %s_target: valid=%b pc=%h inst=%h addr=%h, required 1 %h %h %h",
               name, if_valid, if_pc, if_inst, imem_addr, bt, mem_word(bt), bt + 16'd2);
    end
  endtask

  task automatic test_flush();
    flush_sequence("flush", 1'b1, 16'h0040);
  endtask

  task automatic test_flush_over_stall();
    flush_sequence("flush_stall", 1'b0, 16'h0080);
  endtask

  task automatic test_wrap();
    flush_sequence("wrap", 1'b1, 16'hFFFE);
    n_checks++;
    if (imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_pc: addr=%h, required 0000", imem_addr);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b1, 16'h0100);
    flush = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem_addr !== 16'h0000 || if_pc !== 16'h0000 || if_inst !== 16'h0000 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%h pc=%h inst=%h valid=%b, required 0000 0000 0000 0",
               imem_addr, if_pc, if_inst, if_valid);
    end
    #1;
    reset = 1'b0;
    model_reset();
    tick(1'b0, 1'b1, 16'h0000);
    n_checks++;
    if (if_pc !== 16'h0000 || if_inst !== 16'h1111 || if_valid !== 1'b1 || imem_addr !== 16'h0002) begin
      n_fail++;
      $display("FAIL after_reset_fetch: pc=%h inst=%h valid=%b addr=%h, required 0000 1111 1 0002",
               if_pc, if_inst, if_valid, imem_addr);
    end
  endtask

  task automatic test_random();
    logic f, s;
    logic [15:0] bt;
    for (int i = 0; i < 400; i++) begin
      f  = ($urandom_range(0, 7) == 0);
      s  = (m_bub > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bt = 16'($urandom);
      tick(f, s, bt);
      n_checks++;
      if (imem_addr !== m_pc || if_pc !== m_if_pc || if_inst !== m_if_inst ||
          if_valid !== m_if_valid || if_opcode !== m_if_inst[15:12]) begin
        n_fail++;
        $display("FAIL random_%0d: addr=%h pc=%h inst=%h valid=%b op=%h, required %h %h %h %b %h",
                 i, imem_addr, if_pc, if_inst, if_valid, if_opcode,
                 m_pc, m_if_pc, m_if_inst, m_if_valid, m_if_inst[15:12]);
      end
    end
  endtask

`ifdef FETCH_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 16'h0200);
    n_checks++;
    if (stall_count !== 16'(m_stalls) || flush_count !== 16'(m_flushes) || stall_count !== 16'd5) begin
      n_fail++;
      $display("FAIL perf_counts: stall=%0d flush=%0d, required 5 2", stall_count, flush_count);
    end
    for (int i = 0; i < 65540; i++) tick(1'b0, 1'b0, 16'h0000);
    n_checks++;
    if (stall_count !== 16'hFFFF || flush_count !== 16'd2) begin
      n_fail++;
      $display("FAIL perf_saturate: stall=%h flush=%h, required FFFF 0002", stall_count, flush_count);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_advance();
    test_stall();
    test_flush();
    test_flush_over_stall();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef FETCH_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
